// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the RV32 control unit.
//   CTRL_W and field bit positions of the 12-bit control word,
//   opcode[6:2] constants, decoded control-word constants and
//   the halt FSM state encoding.
package ctrl_pkg;

    localparam int CTRL_W = 12;

    // Control word field positions (MSB to LSB)
    localparam int BIT_BRANCH   = 11;
    localparam int BIT_MEMREAD  = 10;
    localparam int BIT_MEMTOREG = 9;
    localparam int BIT_ALUOP_HI = 8;
    localparam int BIT_ALUOP_LO = 7;
    localparam int BIT_MEMWRITE = 6;
    localparam int BIT_ALUSRC   = 5;
    localparam int BIT_REGWRITE = 4;
    localparam int BIT_ITYPE    = 3;
    localparam int BIT_AJ_HI    = 2;
    localparam int BIT_AJ_LO    = 1;
    localparam int BIT_LUI      = 0;

    // opcode[6:2]
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    // Decoded control words
    localparam logic [CTRL_W-1:0] CW_R      = 12'h110;
    localparam logic [CTRL_W-1:0] CW_LOAD   = 12'h630;
    localparam logic [CTRL_W-1:0] CW_STORE  = 12'h260;
    localparam logic [CTRL_W-1:0] CW_BRANCH = 12'h880;
    localparam logic [CTRL_W-1:0] CW_IMM    = 12'h138;
    localparam logic [CTRL_W-1:0] CW_JAL    = 12'h9B2;
    localparam logic [CTRL_W-1:0] CW_JALR   = 12'h932;
    localparam logic [CTRL_W-1:0] CW_AUIPC  = 12'h036;
    localparam logic [CTRL_W-1:0] CW_LUI    = 12'h131;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode[6:2] -> control word decoder.
//   opcode  in  5   instruction bits [6:2]
//   ctrl    out 12  decoded control word (0 for system/illegal)
//   sys     out 1   system (halt) instruction
//   illegal out 1   opcode not recognised
module control_decode
    import ctrl_pkg::*;
#(
    parameter int SUPPORT_SYSTEM = 1
) (
    input  logic [4:0]        opcode,
    output logic [CTRL_W-1:0] ctrl,
    output logic              sys,
    output logic              illegal
);

    always_comb begin
        ctrl    = '0;
        sys     = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_R:      ctrl = CW_R;
            OP_LOAD:   ctrl = CW_LOAD;
            OP_STORE:  ctrl = CW_STORE;
            OP_BRANCH: ctrl = CW_BRANCH;
            OP_IMM:    ctrl = CW_IMM;
            OP_JAL:    ctrl = CW_JAL;
            OP_JALR:   ctrl = CW_JALR;
            OP_AUIPC:  ctrl = CW_AUIPC;
            OP_LUI:    ctrl = CW_LUI;
            OP_SYSTEM: begin
                if (SUPPORT_SYSTEM != 0) sys = 1'b1;
                else                     illegal = 1'b1;
            end
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: decodes opcode[6:2] and carries the control word
// through PIPE_DEPTH registered stages with per-stage valid, handling
// stall (bubble into stage 0), flush of the FLUSH_DEPTH youngest stages and
// a system-halt FSM (RUN -> DRAIN -> HALTED -> RUN on resume).
//   clk, rst    clock (rising), asynchronous active-high reset
//   in_valid    IF/ID holds a real instruction
//   opcode      instruction bits [6:2]
//   stall       insert bubble into stage 0
//   flush       clear stages 0..FLUSH_DEPTH-1
//   resume      leave HALTED
//   ctrl_pipe   stage k control word at [12k+11:12k]
//   valid_pipe  per-stage valid
//   illegal     one-cycle pulse after an illegal opcode is accepted
//   halt_req    freeze PC/IF-ID (state != RUN)
//   halted      state == HALTED
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH     = 3,
    parameter int FLUSH_DEPTH    = 2,
    parameter int SUPPORT_SYSTEM = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [4:0]                   opcode,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         resume,
    output logic [PIPE_DEPTH*CTRL_W-1:0] ctrl_pipe,
    output logic [PIPE_DEPTH-1:0]        valid_pipe,
    output logic                         illegal,
    output logic                         halt_req,
    output logic                         halted
);

    localparam logic [PIPE_DEPTH-1:0] FLUSH_MASK = PIPE_DEPTH'((1 << FLUSH_DEPTH) - 1);

    logic [PIPE_DEPTH-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [PIPE_DEPTH-1:0]             valid_q, valid_d;
    logic [PIPE_DEPTH-1:0]             sys_q, sys_d;

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_sys;
    logic              dec_illegal;

    state_t state, state_d;

    logic accept;
    logic load;
    logic sys_flushed;

    control_decode #(
        .SUPPORT_SYSTEM(SUPPORT_SYSTEM)
    ) u_decode (
        .opcode  (opcode),
        .ctrl    (dec_ctrl),
        .sys     (dec_sys),
        .illegal (dec_illegal)
    );

    assign accept = (state == ST_RUN) && in_valid && !stall && !flush;
    // Illegal opcodes are accepted (for the pulse) but enter as a bubble
    assign load   = accept && !dec_illegal;

    // The halt instruction was in a flushed stage: the drain is cancelled
    assign sys_flushed = flush && ((sys_q & FLUSH_MASK) != '0);

    always_comb begin
        ctrl_d  = '0;
        valid_d = '0;
        sys_d   = '0;
        if (load) begin
            ctrl_d[0]  = dec_ctrl;
            valid_d[0] = 1'b1;
            sys_d[0]   = dec_sys;
        end
        for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
            ctrl_d[k]  = ctrl_q[k-1];
            valid_d[k] = valid_q[k-1];
            sys_d[k]   = sys_q[k-1];
        end
        if (flush) begin
            for (int unsigned k = 0; k < FLUSH_DEPTH; k++) begin
                ctrl_d[k]  = '0;
                valid_d[k] = 1'b0;
                sys_d[k]   = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_RUN: begin
                if (load && dec_sys) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (sys_flushed)          state_d = ST_RUN;
                else if (valid_d == '0)   state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (resume) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            valid_q  <= '0;
            sys_q    <= '0;
            illegal  <= 1'b0;
            state    <= ST_RUN;
            halt_req <= 1'b0;
            halted   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            valid_q  <= valid_d;
            sys_q    <= sys_d;
            illegal  <= accept && dec_illegal;
            state    <= state_d;
            halt_req <= (state_d != ST_RUN);
            halted   <= (state_d == ST_HALTED);
        end
    end

    assign ctrl_pipe  = ctrl_q;
    assign valid_pipe = valid_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit (default parameters) plus a
// second instance with SUPPORT_SYSTEM=0 sharing the same stimulus.
module tb_pipelined_control_unit;

    localparam int PD = 3;
    localparam int FD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  opcode;
    logic        stall;
    logic        flush;
    logic        resume;

    logic [PD*12-1:0] ctrl_pipe;
    logic [PD-1:0]    valid_pipe;
    logic             illegal;
    logic             halt_req;
    logic             halted;

    logic [PD*12-1:0] ns_ctrl;
    logic [PD-1:0]    ns_valid;
    logic             ns_illegal;
    logic             ns_halt_req;
    logic             ns_halted;

    pipelined_control_unit #(
        .PIPE_DEPTH(PD), .FLUSH_DEPTH(FD), .SUPPORT_SYSTEM(1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
        .stall(stall), .flush(flush), .resume(resume),
        .ctrl_pipe(ctrl_pipe), .valid_pipe(valid_pipe), .illegal(illegal),
        .halt_req(halt_req), .halted(halted)
    );

    pipelined_control_unit #(
        .PIPE_DEPTH(PD), .FLUSH_DEPTH(FD), .SUPPORT_SYSTEM(0)
    ) dut_ns (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
        .stall(stall), .flush(flush), .resume(resume),
        .ctrl_pipe(ns_ctrl), .valid_pipe(ns_valid), .illegal(ns_illegal),
        .halt_req(ns_halt_req), .halted(ns_halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PD*12-1:0] ctrl;
        logic [PD-1:0]    valid;
        logic             ill;
        logic             hreq;
        logic             hltd;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state (0 RUN, 1 DRAIN, 2 HALTED)
    logic [11:0] m_ctrl [PD];
    logic        m_val  [PD];
    logic        m_sys  [PD];
    int          m_state;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic decode_ref(input logic [4:0] op, output logic [11:0] w,
                              output logic s, output logic il);
        w = 12'h000; s = 1'b0; il = 1'b0;
        case (op)
            5'b01100: w = 12'h110;
            5'b00000: w = 12'h630;
            5'b01000: w = 12'h260;
            5'b11000: w = 12'h880;
            5'b00100: w = 12'h138;
            5'b11011: w = 12'h9B2;
            5'b11001: w = 12'h932;
            5'b00101: w = 12'h036;
            5'b01101: w = 12'h131;
            5'b11100: s = 1'b1;
            default:  il = 1'b1;
        endcase
    endtask

    task automatic model_reset();
        for (int k = 0; k < PD; k++) begin
            m_ctrl[k] = 12'h000; m_val[k] = 1'b0; m_sys[k] = 1'b0;
        end
        m_state = 0;
    endtask

    task automatic compare_out();
        exp_t e;
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("ctrl_pipe",  64'(ctrl_pipe),  64'(e.ctrl));
        check("valid_pipe", 64'(valid_pipe), 64'(e.valid));
        check("illegal",    64'(illegal),    64'(e.ill));
        check("halt_req",   64'(halt_req),   64'(e.hreq));
        check("halted",     64'(halted),     64'(e.hltd));
    endtask

    task automatic step(input logic iv, input logic [4:0] op, input logic st,
                        input logic fl, input logic rs);
        exp_t        e;
        logic [11:0] w;
        logic        s, il, acc, lost, any_valid;
        @(negedge clk);
        in_valid = iv; opcode = op; stall = st; flush = fl; resume = rs;
        decode_ref(op, w, s, il);
        acc  = (m_state == 0) && iv && !st && !fl;
        lost = 1'b0;
        for (int k = 0; k < FD; k++) if (fl && m_sys[k]) lost = 1'b1;
        for (int k = PD-1; k > 0; k--) begin
            m_ctrl[k] = m_ctrl[k-1]; m_val[k] = m_val[k-1]; m_sys[k] = m_sys[k-1];
        end
        m_ctrl[0] = (acc && !il) ? w : 12'h000;
        m_val[0]  = acc && !il;
        m_sys[0]  = acc && !il && s;
        if (fl) for (int k = 0; k < FD; k++) begin
            m_ctrl[k] = 12'h000; m_val[k] = 1'b0; m_sys[k] = 1'b0;
        end
        any_valid = 1'b0;
        for (int k = 0; k < PD; k++) if (m_val[k]) any_valid = 1'b1;
        case (m_state)
            0: if (acc && s) m_state = 1;
            1: if (lost) m_state = 0; else if (!any_valid) m_state = 2;
            default: if (rs) m_state = 0;
        endcase
        for (int k = 0; k < PD; k++) begin
            e.ctrl[k*12 +: 12] = m_ctrl[k];
            e.valid[k]         = m_val[k];
        end
        e.ill  = acc && il;
        e.hreq = (m_state != 0);
        e.hltd = (m_state == 2);
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ops [12];
        ops = '{5'b01100, 5'b00000, 5'b01000, 5'b11000, 5'b00100, 5'b11011,
                5'b11001, 5'b00101, 5'b01101, 5'b11100, 5'b11111, 5'b00010};

        rst = 1'b1; in_valid = 1'b0; opcode = '0; stall = 1'b0; flush = 1'b0; resume = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl",  64'(ctrl_pipe),  64'd0);
        check("rst_valid", 64'(valid_pipe), 64'd0);
        check("rst_hreq",  64'(halt_req),   64'd0);
        check("rst_halted",64'(halted),     64'd0);
        check("rst_ill",   64'(illegal),    64'd0);
        @(negedge clk);
        rst = 1'b0;

        // lw, sw, jal back to back, then drain
        step(1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
        check("lw_stage0", 64'(ctrl_pipe[11:0]), 64'h630);
        step(1'b1, 5'b01000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'b11011, 1'b0, 1'b0, 1'b0);
        check("lw_stage2", 64'(ctrl_pipe[35:24]), 64'h630);
        idle(3);

        // stall bubble
        step(1'b1, 5'b01100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'b01100, 1'b1, 1'b0, 1'b0);
        check("stall_s1", 64'(ctrl_pipe[23:12]), 64'h110);
        idle(3);

        // fill then flush
        step(1'b1, 5'b01100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'b00100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'b11000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'b01100, 1'b0, 1'b1, 1'b0);
        check("flush_s2", 64'(ctrl_pipe[35:24]), 64'h138);
        idle(3);

        // illegal opcode: one-cycle pulse
        step(1'b1, 5'b11111, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
        idle(2);

        // stall + flush together, then system + flush together (not accepted)
        step(1'b1, 5'b00000, 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'b11100, 1'b0, 1'b1, 1'b0);
        idle(3);

        // halt sequence; the SUPPORT_SYSTEM=0 instance sees an illegal opcode
        step(1'b1, 5'b11100, 1'b0, 1'b0, 1'b0);
        check("ns_ill",    64'(ns_illegal),     64'd1);
        check("ns_valid0", 64'(ns_valid[0]),    64'd0);
        check("ns_ctrl0",  64'(ns_ctrl[11:0]),  64'd0);
        check("ns_hreq",   64'(ns_halt_req),    64'd0);
        step(1'b1, 5'b00000, 1'b0, 1'b0, 1'b1);
        check("ns_ill_off",64'(ns_illegal),     64'd0);
        check("ns_halted", 64'(ns_halted),      64'd0);
        step(1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
        check("halted_n3", 64'(halted), 64'd1);
        step(1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
        check("resumed", 64'(halt_req), 64'd0);
        idle(3);

        // drain cancelled by flush while the halt sits in stage 1
        step(1'b1, 5'b11100, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);
        check("cancel_run", 64'(halt_req), 64'd0);
        idle(2);

        // asynchronous reset mid-drain
        step(1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'b11100, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0; resume = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_ctrl",  64'(ctrl_pipe),  64'd0);
        check("arst_valid", 64'(valid_pipe), 64'd0);
        check("arst_hreq",  64'(halt_req),   64'd0);
        check("arst_halted",64'(halted),     64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // randomised traffic against the model
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 ops[$urandom_range(0, 11)],
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
